// File: rtl/prio_sel_pipe.sv
// Two-stage priority selector with a late override path.
// Define PRIO_SEL_IDX_EN to add the out_idx port reporting the selected source.
module prio_sel_pipe #(
  parameter int unsigned  W       = 8,
  parameter int unsigned  N       = 4,
  parameter logic [N-1:0] POL     = 4'b1010,
  parameter int unsigned  OVR_POS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_cond,
  input  logic [W-1:0]     in_dflt,
  input  logic             ovr_cond,
  input  logic [W-1:0]     ovr_data,
  input  logic             late_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data
`ifdef PRIO_SEL_IDX_EN
  ,
  output logic [$clog2(N+2)-1:0] out_idx
`endif
);

  localparam int unsigned IW = $clog2(N + 2);

  logic [N-1:0] w_eff;
  logic [W-1:0] w_prio;
  logic         w_early_miss;
  logic         w_accept;
  logic         w_transfer;
  logic         w_take_ovr;
  logic [W-1:0] w_final;

  logic         r_s1_valid;
  logic [W-1:0] r_s1_prio;
  logic         r_s1_early_miss;
  logic         r_s1_ovr;
  logic         r_s2_valid;
  logic [W-1:0] r_s2_data;

`ifdef PRIO_SEL_IDX_EN
  logic [IW-1:0] w_hit_idx;
  logic [IW-1:0] w_final_idx;
  logic [IW-1:0] r_s1_idx;
  logic [IW-1:0] r_s2_idx;
`endif

  // Lowest set effective bit wins; scanning downward lets the last write be the lowest index.
  always_comb begin
    w_eff  = in_cond ^ POL;
    w_prio = in_dflt;
`ifdef PRIO_SEL_IDX_EN
    w_hit_idx = IW'(N);
`endif
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_eff[i]) begin
        w_prio = in_data[i*W +: W];
`ifdef PRIO_SEL_IDX_EN
        w_hit_idx = IW'(i);
`endif
      end
    end
    w_early_miss = ~|w_eff[OVR_POS-1:0];
  end

  always_comb begin
    w_transfer = r_s1_valid & (~r_s2_valid | out_ready);
    in_ready   = ~rst & (~r_s1_valid | w_transfer);
    w_accept   = in_valid & in_ready;
    // late_ctrl and ovr_data are only meaningful on the S1->S2 transfer cycle.
    w_take_ovr = r_s1_ovr & ~late_ctrl & r_s1_early_miss;
    w_final    = w_take_ovr ? ovr_data : r_s1_prio;
`ifdef PRIO_SEL_IDX_EN
    w_final_idx = w_take_ovr ? IW'(N + 1) : r_s1_idx;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid      <= 1'b0;
      r_s1_prio       <= '0;
      r_s1_early_miss <= 1'b0;
      r_s1_ovr        <= 1'b0;
`ifdef PRIO_SEL_IDX_EN
      r_s1_idx        <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_s1_valid      <= 1'b1;
        r_s1_prio       <= w_prio;
        r_s1_early_miss <= w_early_miss;
        r_s1_ovr        <= ovr_cond;
`ifdef PRIO_SEL_IDX_EN
        r_s1_idx        <= w_hit_idx;
`endif
      end else if (w_transfer) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
`ifdef PRIO_SEL_IDX_EN
      r_s2_idx   <= '0;
`endif
    end else begin
      if (w_transfer) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= w_final;
`ifdef PRIO_SEL_IDX_EN
        r_s2_idx   <= w_final_idx;
`endif
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
`ifdef PRIO_SEL_IDX_EN
  assign out_idx   = r_s2_idx;
`endif

endmodule

// File: tb/tb_prio_sel_pipe.sv
// Scoreboard bench for prio_sel_pipe; builds with or without PRIO_SEL_IDX_EN.
module tb_prio_sel_pipe;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] i;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [3:0]   in_cond;
  logic [7:0]   in_dflt;
  logic         ovr_cond;
  logic [7:0]   ovr_data;
  logic         late_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
`ifdef PRIO_SEL_IDX_EN
  logic [2:0]   out_idx;
`endif

  exp_t scb[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 1;  // 0: always ready, 1: never ready, 2: 1,0,0,1 pattern
  logic [3:0] pat = 4'b1001;
  int   pcnt = 0;

  logic       stalled = 1'b0;
  logic [7:0] held_d;
`ifdef PRIO_SEL_IDX_EN
  logic [2:0] held_i;
`endif

  always #5 clk = ~clk;

  prio_sel_pipe #(
    .W(W), .N(N), .POL(4'b1010), .OVR_POS(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cond(in_cond), .in_dflt(in_dflt), .ovr_cond(ovr_cond), .ovr_data(ovr_data),
    .late_ctrl(late_ctrl), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PRIO_SEL_IDX_EN
    , .out_idx(out_idx)
`endif
  );

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: begin
          out_ready = pat[pcnt];
          pcnt = (pcnt + 1) % 4;
        end
      endcase
    end
  end

  // Monitor: pops on every output handshake, checks held values while stalled.
  always @(negedge clk) begin
    if (out_valid) begin
      if (stalled) begin
        total++;
`ifdef PRIO_SEL_IDX_EN
        if (out_data !== held_d || out_idx !== held_i) begin
          bad++;
          $display("FAIL hold: got %h/%0d exp %h/%0d", out_data, out_idx, held_d, held_i);
        end
`else
        if (out_data !== held_d) begin
          bad++;
          $display("FAIL hold: got %h exp %h", out_data, held_d);
        end
`endif
      end
      if (!out_ready) begin
        stalled = 1'b1;
        held_d = out_data;
`ifdef PRIO_SEL_IDX_EN
        held_i = out_idx;
`endif
      end else begin
        stalled = 1'b0;
        total++;
        if (scb.size() == 0) begin
          bad++;
          $display("FAIL unexpected output: got %h exp none", out_data);
        end else begin
          exp_t e;
          e = scb.pop_front();
`ifdef PRIO_SEL_IDX_EN
          if (out_data !== e.d || out_idx !== e.i) begin
            bad++;
            $display("FAIL out: got %h/%0d exp %h/%0d", out_data, out_idx, e.d, e.i);
          end
`else
          if (out_data !== e.d) begin
            bad++;
            $display("FAIL out: got %h exp %h", out_data, e.d);
          end
`endif
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", name, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge with in_valid low.
  task automatic send(input logic [31:0] d, input logic [3:0] c, input logic [7:0] df,
                      input logic ov, input logic [7:0] ed, input logic [2:0] ei);
    logic ok;
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_cond  = c;
    in_dflt  = df;
    ovr_cond = ov;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e.d = ed;
      e.i = ei;
      scb.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("FAIL accept timeout: got in_ready=0 exp 1");
    end
    in_valid = 1'b0;
  endtask

  // Drives late-path values for the accept cycle, then different ones for the transfer cycle.
  task automatic send_late(input logic [3:0] c, input logic [7:0] df, input logic la,
                           input logic lx, input logic [7:0] ed, input logic [2:0] ei);
    late_ctrl = la;
    ovr_data  = 8'h0F;
    send(32'h44332211, c, df, 1'b1, ed, ei);
    late_ctrl = lx;
    ovr_data  = 8'hC3;
    @(posedge clk);
    #1;
    late_ctrl = 1'b0;
    ovr_data  = 8'h00;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (scb.size() == 0) break;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] kb;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_cond = '0;
    in_dflt = '0;
    ovr_cond = 1'b0;
    ovr_data = '0;
    late_ctrl = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {7'd0, in_ready}, 8'd0);
    check("reset out_valid", {7'd0, out_valid}, 8'd0);
    check("reset out_data", out_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("idle in_ready", {7'd0, in_ready}, 8'd1);
    check("idle out_valid", {7'd0, out_valid}, 8'd0);
    @(posedge clk);
    #1;

    // Default selection and two-cycle latency
    send(32'h44332211, 4'b1010, 8'h5A, 1'b0, 8'h5A, 3'd4);
    @(negedge clk);
    check("latency 1", {7'd0, out_valid}, 8'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("latency 2", {7'd0, out_valid}, 8'd1);
    @(posedge clk);
    #1;

    send(32'h44332211, 4'b1011, 8'h5A, 1'b1, 8'h11, 3'd0);  // hit 0, override blocked
    send(32'h44332211, 4'b1110, 8'h5A, 1'b1, 8'h33, 3'd2);  // hit 2 inside override window
    send(32'h44332211, 4'b0101, 8'h5A, 1'b0, 8'h11, 3'd0);  // all eff set, lowest wins
    send(32'h44332211, 4'b0010, 8'h5A, 1'b0, 8'h44, 3'd3);  // hit 3 only
    drain();
    send_late(4'b1010, 8'h66, 1'b1, 1'b0, 8'hC3, 3'd5);     // late_ctrl high only at accept
    send_late(4'b1010, 8'h77, 1'b0, 1'b1, 8'h77, 3'd4);     // late kill at transfer
    send_late(4'b0010, 8'h5A, 1'b0, 1'b0, 8'hC3, 3'd5);     // hit 3 outside window -> override
    drain();

    // Back-to-back stream under 1,0,0,1 backpressure
    rdy_mode = 2;
    for (int k = 0; k < 16; k++) begin
      kb = 8'(k);
      if (k % 2 == 0)
        send({16'h0, 8'h40 + kb, 8'h0}, 4'b1000, 8'hEE, 1'b0, 8'h40 + kb, 3'd1);
      else
        send(32'h0, 4'b1010, 8'h80 + kb, 1'b0, 8'h80 + kb, 3'd4);
    end
    rdy_mode = 0;
    drain();

    // Reset with both stages full
    rdy_mode = 1;
    send(32'h44332211, 4'b1011, 8'h00, 1'b0, 8'h11, 3'd0);
    send(32'h44332211, 4'b1010, 8'h99, 1'b0, 8'h99, 3'd4);
    rst = 1'b1;
    scb.delete();
    @(negedge clk);
    check("rst in_ready", {7'd0, in_ready}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("post-rst out_valid", {7'd0, out_valid}, 8'd0);
    end
    @(posedge clk);
    #1;
    send(32'h44332211, 4'b1010, 8'hA5, 1'b0, 8'hA5, 3'd4);
    drain();
    check("scoreboard empty", 8'(scb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_sel_pipe.md
PRIO_SEL_PIPE -- requirements
Module: prio_sel_pipe

Interface
REQ-001 SHALL provide parameter W, default 8, data width per channel.
REQ-002 SHALL provide parameter N, default 4, number of conditional channels (N >= 2).
REQ-003 SHALL provide parameter POL, default 4'b1010, N-bit polarity mask; bit i = 1 means cond i active-low.
REQ-004 SHALL provide parameter OVR_POS, default 3, range 1..N; the override considers misses on channels 0..OVR_POS-1.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have the ports below:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input entry offered.
- in_ready  output  1  input entry accepted when high together with in_valid.
- in_data  input  N*W  channel i data at bits [i*W +: W].
- in_cond  input  N  raw channel conditions.
- in_dflt  input  W  data used when no channel hits.
- ovr_cond  input  1  override request (C[3]-style).
- ovr_data  input  W  override data, late path.
- late_ctrl  input  1  late-arriving override kill, late path.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  W  selected result.
- out_idx  output  $clog2(N+2)  selected source, present only with PRIO_SEL_IDX_EN.

Function
REQ-007 SHALL form eff[i] = in_cond[i] XOR POL[i].
REQ-008 SHALL define hit as the lowest i with eff[i] = 1; prio = in_data channel hit, or in_dflt if no bit set.
REQ-009 SHALL define early_miss = 1 when eff[OVR_POS-1:0] is all zero.
REQ-010 SHALL be a two-stage pipeline: stage 1 (S1) registers prio, early_miss and ovr_cond on accept; stage 2 (S2) registers the final result.
REQ-011 SHALL sample late_ctrl and ovr_data on the S1->S2 transfer cycle, not on the accept cycle.
REQ-012 SHALL compute final = ovr_data when S1.ovr_cond & ~late_ctrl & S1.early_miss; otherwise final = S1.prio.
REQ-013 SHALL transfer S1->S2 when S1 valid and (S2 empty or out_ready).
REQ-014 SHALL drive in_ready = ~S1_valid | transfer, combinationally.
REQ-015 SHALL give latency of 2 cycles from accept to out_valid when there is no backpressure, at throughput 1 entry per cycle.
REQ-016 SHALL hold out_data and out_idx stable while out_valid & ~out_ready.
REQ-017 SHALL lose no entry and duplicate no entry under any out_ready pattern.
REQ-018 SHALL pass an entry straight through on the same edge when accept, transfer and output handshake all occur together.
REQ-019 SHALL ignore all input data, conditions and late-path signals when the corresponding stage is not loading.

Reset
REQ-020 SHALL, while rst is high at a clock edge, clear S1 and S2 valid, out_valid, out_data and out_idx to 0.
REQ-021 SHALL force in_ready to 0 during the reset cycle.
REQ-022 SHALL discard in-flight entries on reset mid-operation, with no output after release until a new accept.

Configuration
REQ-023 SHALL, when macro PRIO_SEL_IDX_EN is defined, add port out_idx: hit index 0..N-1, N for default, N+1 for override; registered alongside out_data.
REQ-024 SHALL, without PRIO_SEL_IDX_EN, omit out_idx and its registers; out_data behaviour is identical in both builds.

Verification
REQ-025 SHALL cover: defaults, in_cond=4'b1010 (no eff bit set), in_dflt=8'h5A, ovr_cond=0 -> out_data=8'h5A two cycles after accept, out_idx=4.
REQ-026 SHALL cover: in_cond=4'b1011, channel 0 data 8'h11 -> out_data=8'h11, out_idx=0; ovr_cond=1 has no effect because early_miss=0.
REQ-027 SHALL cover: eff=0, ovr_cond=1, ovr_data=8'hC3; late_ctrl=0 at the transfer cycle -> 8'hC3, idx 5; late_ctrl=1 at transfer (0 at accept) -> in_dflt.
REQ-028 SHALL cover: 16 back-to-back entries with out_ready toggling 1,0,0,1 -> all 16 received in order, out_data stable while stalled.
REQ-029 SHALL cover: rst asserted for one cycle with S1 and S2 full -> out_valid=0 the next cycle, no stale output after release.
REQ-030 SHALL cover: build without PRIO_SEL_IDX_EN -> out_data sequence bit-identical to the build with the macro.
